// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - two-slot execute stage: operand hold (X) and registered result (M)
// Optional build macro: EX_FORWARD_EN (forward M result into X operands).
module ex_stage #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // decode -> EX
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic [DATA_WIDTH-1:0] in_rs1_val,
  input  logic [DATA_WIDTH-1:0] in_rs2_val,
  input  logic [DATA_WIDTH-1:0] in_imm,
  input  logic                  in_a_sel,
  input  logic                  in_b_sel,
  input  logic [3:0]            in_alu_op,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [4:0]            in_rd,
  input  logic                  in_wen,
  input  logic                  in_is_branch,
  input  logic [2:0]            in_funct3,
  input  logic                  flush,
  // external ALU
  output logic [DATA_WIDTH-1:0] alu_A,
  output logic [DATA_WIDTH-1:0] alu_B,
  output logic [3:0]            alu_op,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_zero,
  // EX -> MEM
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic [DATA_WIDTH-1:0] out_br_target,
  output logic [4:0]            out_rd,
  output logic                  out_wen,
  output logic                  out_br_taken
);

  // slot X: the instruction currently driving the ALU
  logic                  x_valid;
  logic [DATA_WIDTH-1:0] x_pc;
  logic [DATA_WIDTH-1:0] x_rs1_val;
  logic [DATA_WIDTH-1:0] x_rs2_val;
  logic [DATA_WIDTH-1:0] x_imm;
  logic                  x_a_sel;
  logic                  x_b_sel;
  logic [3:0]            x_alu_op;
  logic [4:0]            x_rs1;
  logic [4:0]            x_rs2;
  logic [4:0]            x_rd;
  logic                  x_wen;
  logic                  x_is_branch;
  logic [2:0]            x_funct3;

  // slot M: registered results presented downstream
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_result;
  logic [DATA_WIDTH-1:0] m_br_target;
  logic [4:0]            m_rd;
  logic                  m_wen;
  logic                  m_br_taken;

  logic                  m_accept;
  logic                  x_to_m;
  logic                  x_accept;
  logic [DATA_WIDTH-1:0] rs1_op;
  logic [DATA_WIDTH-1:0] rs2_op;
  logic [DATA_WIDTH-1:0] br_target;
  logic                  br_taken;

  // M can take a new result when empty or when its current one leaves this cycle
  assign m_accept = !m_valid || out_ready;
  assign x_to_m   = x_valid && m_accept && !flush;
  assign in_ready = !rst && !flush && (!x_valid || m_accept);
  assign x_accept = in_valid && in_ready;

`ifdef EX_FORWARD_EN
  logic fwd_ok;
  logic fwd_rs1;
  logic fwd_rs2;

  // the older instruction in M writes a register X is about to read
  assign fwd_ok  = m_valid && m_wen && (m_rd != 5'd0);
  assign fwd_rs1 = fwd_ok && (x_rs1 == m_rd);
  assign fwd_rs2 = fwd_ok && (x_rs2 == m_rd);
  assign rs1_op  = fwd_rs1 ? m_result : x_rs1_val;
  assign rs2_op  = fwd_rs2 ? m_result : x_rs2_val;
`else
  assign rs1_op  = x_rs1_val;
  assign rs2_op  = x_rs2_val;
`endif

  assign alu_A     = x_a_sel ? x_pc : rs1_op;
  assign alu_B     = x_b_sel ? x_imm : rs2_op;
  assign alu_op    = x_alu_op;
  assign br_target = x_pc + x_imm;

  // branch decision from ALU flags; non-branches and reserved funct3 never take
  always_comb begin
    br_taken = 1'b0;
    if (x_is_branch) begin
      case (x_funct3)
        3'b000:         br_taken = alu_zero;
        3'b001:         br_taken = !alu_zero;
        3'b100, 3'b110: br_taken = alu_result[0];
        3'b101, 3'b111: br_taken = !alu_result[0];
        default:        br_taken = 1'b0;
      endcase
    end
  end

  // slot X: load on accept, empty when it moves to M, cleared by flush
  always_ff @(posedge clk) begin
    if (rst) begin
      x_valid     <= 1'b0;
      x_pc        <= '0;
      x_rs1_val   <= '0;
      x_rs2_val   <= '0;
      x_imm       <= '0;
      x_a_sel     <= 1'b0;
      x_b_sel     <= 1'b0;
      x_alu_op    <= 4'd0;
      x_rs1       <= 5'd0;
      x_rs2       <= 5'd0;
      x_rd        <= 5'd0;
      x_wen       <= 1'b0;
      x_is_branch <= 1'b0;
      x_funct3    <= 3'd0;
    end else if (flush) begin
      x_valid     <= 1'b0;
    end else if (x_accept) begin
      x_valid     <= 1'b1;
      x_pc        <= in_pc;
      x_rs1_val   <= in_rs1_val;
      x_rs2_val   <= in_rs2_val;
      x_imm       <= in_imm;
      x_a_sel     <= in_a_sel;
      x_b_sel     <= in_b_sel;
      x_alu_op    <= in_alu_op;
      x_rs1       <= in_rs1;
      x_rs2       <= in_rs2;
      x_rd        <= in_rd;
      x_wen       <= in_wen;
      x_is_branch <= in_is_branch;
      x_funct3    <= in_funct3;
    end else if (x_to_m) begin
      x_valid     <= 1'b0;
    end
  end

  // slot M: capture ALU/branch results from X, hold while downstream stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid     <= 1'b0;
      m_result    <= '0;
      m_br_target <= '0;
      m_rd        <= 5'd0;
      m_wen       <= 1'b0;
      m_br_taken  <= 1'b0;
    end else if (flush) begin
      m_valid     <= 1'b0;
    end else if (x_to_m) begin
      m_valid     <= 1'b1;
      m_result    <= alu_result;
      m_br_target <= br_target;
      m_rd        <= x_rd;
      m_wen       <= x_wen && !x_is_branch;
      m_br_taken  <= br_taken;
    end else if (out_ready) begin
      m_valid     <= 1'b0;
    end
  end

  assign out_valid     = m_valid;
  assign out_result    = m_result;
  assign out_br_target = m_br_target;
  assign out_rd        = m_rd;
  assign out_wen       = m_wen;
  assign out_br_taken  = m_br_taken;

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - self-checking bench for ex_stage with behavioural ALU and result model
module tb_ex_stage;

`ifdef EX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic        a_sel;
    logic        b_sel;
    logic [3:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        wen;
    logic        br;
    logic [2:0]  f3;
  } instr_t;

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] target;
    logic [4:0]  rd;
    logic        wen;
    logic        taken;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc, in_rs1_val, in_rs2_val, in_imm;
  logic        in_a_sel, in_b_sel;
  logic [3:0]  in_alu_op;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_wen, in_is_branch;
  logic [2:0]  in_funct3;
  logic        flush;
  logic [31:0] alu_A, alu_B;
  logic [3:0]  alu_op;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result, out_br_target;
  logic [4:0]  out_rd;
  logic        out_wen, out_br_taken;

  int checks = 0;
  int errors = 0;
  exp_t expq[$];

  always #5 clk = ~clk;

  // reference ALU: add, sub, signed/unsigned less-than, anything else passes A
  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'b0010: return a + b;
      4'b1010: return a - b;
      4'b1011: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1111: return (a < b) ? 32'd1 : 32'd0;
      default: return a;
    endcase
  endfunction

  assign alu_result = alu_f(alu_op, alu_A, alu_B);
  assign alu_zero   = (alu_result == 32'd0);

  ex_stage #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm),
    .in_a_sel(in_a_sel), .in_b_sel(in_b_sel), .in_alu_op(in_alu_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_wen(in_wen),
    .in_is_branch(in_is_branch), .in_funct3(in_funct3), .flush(flush),
    .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_br_target(out_br_target), .out_rd(out_rd),
    .out_wen(out_wen), .out_br_taken(out_br_taken)
  );

  function automatic instr_t mk(input logic [3:0] op, input logic [31:0] rs1v, input logic [31:0] rs2v,
                                input logic [31:0] pc, input logic [31:0] imm, input logic as, input logic bs,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                input logic wen, input logic br, input logic [2:0] f3);
    instr_t i;
    i.op = op; i.rs1_val = rs1v; i.rs2_val = rs2v; i.pc = pc; i.imm = imm;
    i.a_sel = as; i.b_sel = bs; i.rs1 = rs1; i.rs2 = rs2; i.rd = rd;
    i.wen = wen; i.br = br; i.f3 = f3;
    return i;
  endfunction

  // expected EX result; prev is the immediately older instruction, still in flight when fwd_avail
  function automatic exp_t model(input instr_t i, input bit fwd_avail, input exp_t prev);
    exp_t e;
    logic [31:0] ra, rb, a, b, r;
    ra = i.rs1_val;
    rb = i.rs2_val;
    if (FWD && fwd_avail && prev.wen && prev.rd != 5'd0) begin
      if (i.rs1 == prev.rd) ra = prev.result;
      if (i.rs2 == prev.rd) rb = prev.result;
    end
    a = i.a_sel ? i.pc : ra;
    b = i.b_sel ? i.imm : rb;
    r = alu_f(i.op, a, b);
    e.result = r;
    e.target = i.pc + i.imm;
    e.rd     = i.rd;
    e.wen    = i.wen && !i.br;
    e.taken  = 1'b0;
    if (i.br) begin
      if (i.f3 == 3'b000) e.taken = (r == 32'd0);
      else if (i.f3 == 3'b001) e.taken = (r != 32'd0);
      else if (i.f3 == 3'b100 || i.f3 == 3'b110) e.taken = r[0];
      else if (i.f3 == 3'b101 || i.f3 == 3'b111) e.taken = !r[0];
    end
    return e;
  endfunction

  task automatic drive(input instr_t i, input logic v);
    in_valid = v;
    in_pc = i.pc; in_rs1_val = i.rs1_val; in_rs2_val = i.rs2_val; in_imm = i.imm;
    in_a_sel = i.a_sel; in_b_sel = i.b_sel; in_alu_op = i.op;
    in_rs1 = i.rs1; in_rs2 = i.rs2; in_rd = i.rd; in_wen = i.wen;
    in_is_branch = i.br; in_funct3 = i.f3;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    instr_t i;
    i = mk(4'b0010, 32'd1, 32'd2, 32'd0, 32'd0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd4, 1'b1, 1'b0, 3'd0);
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(i, 1'b1);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b exp 0", in_ready); end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
    end
    checks++;
    if ({out_result, out_br_target, out_rd, out_wen, out_br_taken} !== 71'd0)
      begin errors++; $display("FAIL reset_outputs: result=%h target=%h rd=%0d wen=%b taken=%b exp all 0",
                              out_result, out_br_target, out_rd, out_wen, out_br_taken); end
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready: got %b exp 1", in_ready); end
  endtask

  task automatic test_add();
    instr_t i;
    i = mk(4'b0010, 32'd5, 32'd7, 32'h40, 32'd0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 3'd0);
    @(negedge clk);
    out_ready = 1'b1;
    drive(i, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL add_latency_early: out_valid=%b exp 0", out_valid); end
    @(negedge clk); #1;
    checks++;
    if ({out_valid, out_result, out_rd, out_wen} !== {1'b1, 32'd12, 5'd3, 1'b1})
      begin errors++; $display("FAIL add_result: valid=%b result=%0d rd=%0d wen=%b exp 1 12 3 1",
                              out_valid, out_result, out_rd, out_wen); end
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL add_drain: out_valid=%b exp 0", out_valid); end
  endtask

  task automatic test_branch();
    instr_t i1, i2, i3;
    i1 = mk(4'b1011, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 3'b100);
    i2 = mk(4'b1111, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 3'b110);
    i3 = mk(4'b1011, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 3'b010);
    @(negedge clk);
    out_ready = 1'b1;
    drive(i1, 1'b1);
    @(negedge clk);
    drive(i2, 1'b1);
    @(negedge clk);
    drive(i3, 1'b1);
    #1;
    checks++;
    if ({out_valid, out_br_taken, out_br_target, out_wen} !== {1'b1, 1'b1, 32'h120, 1'b0})
      begin errors++; $display("FAIL blt_taken: valid=%b taken=%b target=%h wen=%b exp 1 1 120 0",
                              out_valid, out_br_taken, out_br_target, out_wen); end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_br_taken, out_br_target, out_wen} !== {1'b1, 1'b0, 32'h120, 1'b0})
      begin errors++; $display("FAIL bltu_not_taken: valid=%b taken=%b target=%h wen=%b exp 1 0 120 0",
                              out_valid, out_br_taken, out_br_target, out_wen); end
    @(negedge clk); #1;
    checks++;
    if ({out_valid, out_br_taken, out_result} !== {1'b1, 1'b0, 32'd1})
      begin errors++; $display("FAIL illegal_funct3: valid=%b taken=%b result=%0d exp 1 0 1",
                              out_valid, out_br_taken, out_result); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    instr_t a, b, c;
    a = mk(4'b0010, 32'd10, 32'd1, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 3'd0);
    b = mk(4'b0010, 32'd20, 32'd2, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd8, 1'b1, 1'b0, 3'd0);
    c = mk(4'b0010, 32'd30, 32'd3, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 3'd0);
    @(negedge clk);
    out_ready = 1'b0;
    drive(a, 1'b1);
    @(negedge clk);
    drive(b, 1'b1);
    @(negedge clk);
    drive(c, 1'b1);
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_full: got %b exp 0 (cycle %0d)", in_ready, k); end
      checks++;
      if ({out_valid, out_result, out_rd} !== {1'b1, 32'd11, 5'd7})
        begin errors++; $display("FAIL bp_hold: valid=%b result=%0d rd=%0d exp 1 11 7 (cycle %0d)",
                                out_valid, out_result, out_rd, k); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready: got %b exp 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_result, out_rd} !== {1'b1, 32'd22, 5'd8})
      begin errors++; $display("FAIL bp_second: valid=%b result=%0d rd=%0d exp 1 22 8", out_valid, out_result, out_rd); end
    @(negedge clk); #1;
    checks++;
    if ({out_valid, out_result, out_rd} !== {1'b1, 32'd33, 5'd9})
      begin errors++; $display("FAIL bp_third: valid=%b result=%0d rd=%0d exp 1 33 9", out_valid, out_result, out_rd); end
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: out_valid=%b exp 0", out_valid); end
  endtask

  task automatic test_flush();
    instr_t a, b, c;
    a = mk(4'b0010, 32'd1, 32'd1, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 3'd0);
    b = mk(4'b0010, 32'd2, 32'd2, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd2, 1'b1, 1'b0, 3'd0);
    c = mk(4'b0010, 32'd3, 32'd3, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 3'd0);
    @(negedge clk);
    out_ready = 1'b0;
    drive(a, 1'b1);
    @(negedge clk);
    drive(b, 1'b1);
    @(negedge clk);
    drive(c, 1'b1);
    out_ready = 1'b1;
    flush = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b exp 0", in_ready); end
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b exp 0 (cycle %0d)", out_valid, k); end
      @(negedge clk);
    end
  endtask

  task automatic test_forward();
    instr_t i1, i2;
    logic [31:0] exp2;
    i1 = mk(4'b0010, 32'd4, 32'd6, 32'h0, 32'h0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 3'd0);
    i2 = mk(4'b0010, 32'd77, 32'd0, 32'h0, 32'd1, 1'b0, 1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 3'd0);
    exp2 = FWD ? 32'd11 : 32'd78;
    @(negedge clk);
    out_ready = 1'b1;
    drive(i1, 1'b1);
    @(negedge clk);
    drive(i2, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_result, out_rd} !== {1'b1, 32'd10, 5'd5})
      begin errors++; $display("FAIL fwd_first: valid=%b result=%0d rd=%0d exp 1 10 5", out_valid, out_result, out_rd); end
    @(negedge clk); #1;
    checks++;
    if ({out_valid, out_result, out_rd} !== {1'b1, exp2, 5'd6})
      begin errors++; $display("FAIL fwd_second: valid=%b result=%0d rd=%0d exp 1 %0d 6", out_valid, out_result, out_rd, exp2); end
    @(negedge clk);
  endtask

  function automatic instr_t rand_instr();
    instr_t i;
    logic [3:0] ops [5];
    ops[0] = 4'b0010; ops[1] = 4'b1010; ops[2] = 4'b1011; ops[3] = 4'b1111; ops[4] = 4'($urandom);
    i.op      = ops[$urandom_range(0, 4)];
    i.rs1_val = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
    i.rs2_val = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
    i.pc      = $urandom;
    i.imm     = $urandom;
    i.a_sel   = ($urandom_range(0, 3) == 0);
    i.b_sel   = ($urandom_range(0, 3) == 0);
    i.rs1     = 5'($urandom_range(0, 3));
    i.rs2     = 5'($urandom_range(0, 3));
    i.rd      = 5'($urandom_range(0, 3));
    i.wen     = ($urandom_range(0, 3) != 0);
    i.br      = ($urandom_range(0, 9) < 3);
    i.f3      = 3'($urandom);
    return i;
  endfunction

  task automatic test_random();
    instr_t i;
    exp_t prev, e;
    bit fwd_avail;
    do_reset();
    expq.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      i = rand_instr();
      drive(i, ($urandom_range(0, 9) < 7));
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      checks++;
      if (in_ready !== ((expq.size() < 2) || out_ready))
        begin errors++; $display("FAIL rand_in_ready: got %b exp %b (pending %0d)", in_ready, ((expq.size() < 2) || out_ready), expq.size()); end
      if (out_valid === 1'b1) begin
        checks++;
        if (expq.size() == 0) begin
          errors++; $display("FAIL rand_spurious: out_valid=1 with nothing pending");
        end else if ({out_result, out_br_target, out_rd, out_wen, out_br_taken} !== expq[0]) begin
          errors++;
          $display("FAIL rand_output: got result=%h target=%h rd=%0d wen=%b taken=%b exp result=%h target=%h rd=%0d wen=%b taken=%b",
                   out_result, out_br_target, out_rd, out_wen, out_br_taken,
                   expq[0].result, expq[0].target, expq[0].rd, expq[0].wen, expq[0].taken);
        end
        if (out_ready && expq.size() > 0) void'(expq.pop_front());
      end
      if (in_valid && in_ready === 1'b1) begin
        fwd_avail = (expq.size() > 0);
        prev = fwd_avail ? expq[$] : '0;
        e = model(i, fwd_avail, prev);
        expq.push_back(e);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && expq.size() > 0; k++) begin
      #1;
      if (out_valid === 1'b1) begin
        checks++;
        if ({out_result, out_br_target, out_rd, out_wen, out_br_taken} !== expq[0])
          begin errors++; $display("FAIL drain_output: got result=%h rd=%0d exp result=%h rd=%0d",
                                  out_result, out_rd, expq[0].result, expq[0].rd); end
        void'(expq.pop_front());
      end
      @(negedge clk);
    end
    checks++;
    if (expq.size() != 0) begin errors++; $display("FAIL drain_timeout: %0d results never appeared", expq.size()); end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive('0, 1'b0);
    test_reset();
    test_add();
    test_branch();
    test_backpressure();
    test_flush();
    test_forward();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not complete, errors so far %0d", errors);
    $fatal(1, "timeout");
  end

endmodule
